// File: rtl/pipelined_decode_ctrl.sv
// Registered IF/ID decode controller driving the ID/EX control word, with jump-shadow
// squashing, halt drain sequencing and bubble insertion. ILLEGAL_TRAP_EN adds illegal_trap.
module pipelined_decode_ctrl #(
  parameter int unsigned ALU_OP_W     = 3,
  parameter int unsigned SHADOW       = 1,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instruction,
  input  logic                instr_valid,
  input  logic                stall_b,
  input  logic                flush,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src,
  output logic                branch,
  output logic                branch_ne,
  output logic                jump,
  output logic                ctrl_valid,
  output logic                halted
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic                illegal_trap
`endif
);

  localparam int unsigned SH_W = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
  localparam int unsigned DR_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_NOP = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(6);

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                mem_read;
    logic                mem_write;
    logic                mem_reg;
    logic                reg_dst;
    logic                reg_write;
    logic                alu_src;
    logic                branch;
    logic                branch_ne;
    logic                jump;
    logic                ctrl_valid;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '{alu_op: ALU_NOP, default: 1'b0};

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED
  } state_t;

  state_t          state;
  ctrl_t           ctrl_q;
  ctrl_t           dec;
  logic            dec_legal;
  logic            dec_halt;
  logic            dec_jump;
  logic [SH_W-1:0] shadow_cnt;
  logic [DR_W-1:0] drain_cnt;
  logic            halted_q;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            unused_instr_bits;

  assign opcode            = instruction[31:26];
  assign funct             = instruction[5:0];
  assign unused_instr_bits = ^instruction[25:6];

  always_comb begin
    dec       = BUBBLE;
    dec_legal = 1'b0;
    dec_halt  = 1'b0;
    dec_jump  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst   = 1'b1;
        dec.reg_write = 1'b1;
        dec_legal     = 1'b1;
        case (funct)
          FN_ADD:  dec.alu_op = ALU_ADD;
          FN_SUB:  dec.alu_op = ALU_SUB;
          FN_AND:  dec.alu_op = ALU_AND;
          FN_OR:   dec.alu_op = ALU_OR;
          FN_SLT:  dec.alu_op = ALU_SLT;
          default: dec_legal  = 1'b0;
        endcase
      end
      OP_LW: begin
        dec.alu_op    = ALU_ADD;
        dec.mem_read  = 1'b1;
        dec.mem_reg   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_legal     = 1'b1;
      end
      OP_SW: begin
        dec.alu_op    = ALU_ADD;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_legal     = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_op    = ALU_ADD;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec_legal     = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_op = ALU_SUB;
        dec.branch = 1'b1;
        dec_legal  = 1'b1;
      end
      OP_BNE: begin
        dec.alu_op    = ALU_SUB;
        dec.branch    = 1'b1;
        dec.branch_ne = 1'b1;
        dec_legal     = 1'b1;
      end
      OP_J: begin
        dec.alu_op = ALU_NOP;
        dec.jump   = 1'b1;
        dec_jump   = 1'b1;
        dec_legal  = 1'b1;
      end
      OP_HALT: dec_halt = 1'b1;
      default: ;
    endcase
    dec.ctrl_valid = dec_legal;
  end

  // Control word defaults to the bubble each cycle so jump can only ever pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_RUN;
      ctrl_q       <= BUBBLE;
      shadow_cnt   <= '0;
      drain_cnt    <= '0;
      halted_q     <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_trap <= 1'b0;
`endif
    end else begin
      ctrl_q <= BUBBLE;
      case (state)
        S_RUN: begin
          if (flush) begin
            shadow_cnt <= '0;
          end else if (!stall_b || !instr_valid) begin
            shadow_cnt <= shadow_cnt;
          end else if (shadow_cnt != '0) begin
            shadow_cnt <= shadow_cnt - SH_W'(1);
          end else if (dec_halt) begin
            state     <= S_DRAIN;
            drain_cnt <= DR_W'(DRAIN_CYCLES);
          end else if (!dec_legal) begin
`ifdef ILLEGAL_TRAP_EN
            illegal_trap <= 1'b1;
            state        <= S_HALTED;
            halted_q     <= 1'b1;
`endif
          end else begin
            ctrl_q <= dec;
            if (dec_jump) shadow_cnt <= SH_W'(SHADOW);
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt - DR_W'(1);
          if (drain_cnt == DR_W'(1)) begin
            state    <= S_HALTED;
            halted_q <= 1'b1;
          end
        end
        S_HALTED: halted_q <= 1'b1;
        default:  state    <= S_RUN;
      endcase
    end
  end

  assign alu_op     = ctrl_q.alu_op;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign mem_reg    = ctrl_q.mem_reg;
  assign reg_dst    = ctrl_q.reg_dst;
  assign reg_write  = ctrl_q.reg_write;
  assign alu_src    = ctrl_q.alu_src;
  assign branch     = ctrl_q.branch;
  assign branch_ne  = ctrl_q.branch_ne;
  assign jump       = ctrl_q.jump;
  assign ctrl_valid = ctrl_q.ctrl_valid;
  assign halted     = halted_q;

endmodule

// File: tb/tb_pipelined_decode_ctrl.sv
// Scoreboard bench for pipelined_decode_ctrl (SHADOW=2, DRAIN_CYCLES=3); follows ILLEGAL_TRAP_EN.
module tb_pipelined_decode_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        stall_b;
  logic        flush;
  logic [2:0]  alu_op;
  logic        mem_read, mem_write, mem_reg, reg_dst, reg_write, alu_src;
  logic        branch, branch_ne, jump, ctrl_valid, halted;
  logic        trap_bit;

  pipelined_decode_ctrl #(
    .ALU_OP_W(3),
    .SHADOW(2),
    .DRAIN_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .stall_b(stall_b),
    .flush(flush),
    .alu_op(alu_op),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mem_reg(mem_reg),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src(alu_src),
    .branch(branch),
    .branch_ne(branch_ne),
    .jump(jump),
    .ctrl_valid(ctrl_valid),
    .halted(halted)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal_trap(trap_bit)
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign trap_bit = 1'b0;
`endif

  // {alu_op, mem_read, mem_write, mem_reg, reg_dst, reg_write, alu_src, branch, branch_ne, jump, ctrl_valid, halted, trap}
  localparam logic [14:0] E_BUB  = {3'd1, 9'b000000000, 1'b0, 1'b0, 1'b0};
  localparam logic [14:0] E_BUBH = {3'd1, 9'b000000000, 1'b0, 1'b1, 1'b0};
  localparam logic [14:0] E_TRAP = {3'd1, 9'b000000000, 1'b0, 1'b1, 1'b1};
  localparam logic [14:0] E_ADD  = {3'd0, 9'b000110000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_SUB  = {3'd6, 9'b000110000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_AND  = {3'd2, 9'b000110000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_OR   = {3'd3, 9'b000110000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_SLT  = {3'd4, 9'b000110000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_LW   = {3'd0, 9'b101011000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_SW   = {3'd0, 9'b010001000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_ADDI = {3'd0, 9'b000011000, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_BEQ  = {3'd6, 9'b000000100, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_BNE  = {3'd6, 9'b000000110, 1'b1, 1'b0, 1'b0};
  localparam logic [14:0] E_J    = {3'd1, 9'b000000001, 1'b1, 1'b0, 1'b0};
`ifdef ILLEGAL_TRAP_EN
  localparam logic [14:0] E_TAIL = E_TRAP;
`else
  localparam logic [14:0] E_TAIL = E_BUB;
`endif

  logic [14:0] act;
  assign act = {alu_op, mem_read, mem_write, mem_reg, reg_dst, reg_write, alu_src,
                branch, branch_ne, jump, ctrl_valid, halted, trap_bit};

  int          cyc = 0;
  int          tests_run = 0;
  int          failures = 0;
  int          due_q[$];
  logic [14:0] exp_q[$];
  string       name_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'h12345, fn};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic v, input logic sb, input logic fl,
                       input logic [14:0] exp, input string nm);
    @(posedge clk);
    #1;
    instruction = ins;
    instr_valid = v;
    stall_b     = sb;
    flush       = fl;
    due_q.push_back(cyc + 1);
    exp_q.push_back(exp);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst         = 1'b1;
    instr_valid = 1'b0;
    stall_b     = 1'b1;
    flush       = 1'b0;
    due_q.push_back(cyc + 1);
    exp_q.push_back(E_BUB);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: every control word is due one clock after its stimulus was applied.
  always @(negedge clk) begin
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [14:0] e;
      string       n;
      void'(due_q.pop_front());
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests_run++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %b required %b", n, act, e);
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: run did not complete, %0d checks pending", due_q.size());
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    rst         = 1'b1;
    instruction = '0;
    instr_valid = 1'b0;
    stall_b     = 1'b1;
    flush       = 1'b0;
    do_reset("reset_state");

    tests_run++;
    if (halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_halted: got %b required 0", halted);
    end
    tests_run++;
    if (ctrl_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl_valid: got %b required 0", ctrl_valid);
    end
    tests_run++;
    if (alu_op !== 3'd1) begin
      failures++;
      $display("FAIL reset_alu_op: got %0d required 1", alu_op);
    end

    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "add");
    drive(mk(6'h00, 6'h20), 1, 0, 0, E_BUB, "add_stalled");
    drive(mk(6'h00, 6'h22), 1, 1, 0, E_SUB, "sub");
    drive(mk(6'h00, 6'h24), 1, 1, 0, E_AND, "and");
    drive(mk(6'h00, 6'h25), 1, 1, 0, E_OR,  "or");
    drive(mk(6'h00, 6'h2a), 1, 1, 0, E_SLT, "slt");
    drive(mk(6'h00, 6'h20), 0, 1, 0, E_BUB, "add_invalid");
    drive(mk(6'h23, 6'h00), 1, 1, 0, E_LW,   "lw");
    drive(mk(6'h2b, 6'h00), 1, 1, 0, E_SW,   "sw");
    drive(mk(6'h08, 6'h00), 1, 1, 0, E_ADDI, "addi");
    drive(mk(6'h04, 6'h00), 1, 1, 0, E_BEQ,  "beq");
    drive(mk(6'h05, 6'h00), 1, 1, 0, E_BNE,  "bne");
    drive(mk(6'h00, 6'h20), 1, 1, 1, E_BUB,  "add_flushed");

    drive(mk(6'h02, 6'h00), 1, 1, 0, E_J,   "j1");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB, "j1_shadow_a");
    tests_run++;
    if (jump !== 1'b1) begin
      failures++;
      $display("FAIL j1_jump_pulse: got %b required 1", jump);
    end
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB, "j1_shadow_b");
    tests_run++;
    if (jump !== 1'b0) begin
      failures++;
      $display("FAIL j1_jump_cleared: got %b required 0", jump);
    end
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "j1_after_shadow");

    drive(mk(6'h02, 6'h00), 1, 1, 0, E_J,   "j2");
    drive(mk(6'h00, 6'h20), 1, 0, 0, E_BUB, "j2_stall_a");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB, "j2_shadow_a");
    drive(mk(6'h00, 6'h20), 1, 0, 0, E_BUB, "j2_stall_b");
    drive(mk(6'h00, 6'h20), 0, 1, 0, E_BUB, "j2_invalid");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB, "j2_shadow_b");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "j2_after_shadow");

    drive(mk(6'h02, 6'h00), 1, 1, 0, E_J,   "j3");
    drive(mk(6'h00, 6'h20), 1, 1, 1, E_BUB, "j3_flush");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "j3_after_flush");

    drive(mk(6'h3f, 6'h00), 1, 1, 0, E_BUB,  "halt");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB,  "drain_1");
    drive(mk(6'h00, 6'h20), 1, 1, 1, E_BUB,  "drain_2_flush");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUBH, "halted_first");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUBH, "halted_sticky_a");
    drive(mk(6'h00, 6'h20), 1, 1, 1, E_BUBH, "halted_sticky_b");
    tests_run++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halted_held: got %b required 1", halted);
    end

    do_reset("reset_from_halted");
    drive(mk(6'h3f, 6'h00), 1, 1, 0, E_BUB, "halt_again");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_BUB, "drain_again");
    do_reset("reset_mid_drain");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "add_after_reset");

`ifdef ILLEGAL_TRAP_EN
    drive(mk(6'h11, 6'h00), 1, 1, 0, E_TRAP, "illegal_op_trap");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_TRAP, "trap_sticky");
    do_reset("reset_from_trap");
    drive(mk(6'h00, 6'h21), 1, 1, 0, E_TRAP, "illegal_funct_trap");
`else
    drive(mk(6'h11, 6'h00), 1, 1, 0, E_BUB, "illegal_op");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "add_after_illegal_op");
    drive(mk(6'h00, 6'h21), 1, 1, 0, E_BUB, "illegal_funct");
    drive(mk(6'h00, 6'h20), 1, 1, 0, E_ADD, "add_after_illegal_funct");
`endif

    drive('0, 0, 1, 0, E_TAIL, "idle_tail");
    repeat (3) @(negedge clk);
    #1;
    while (due_q.size() > 0) begin
      void'(due_q.pop_front());
      void'(exp_q.pop_front());
      tests_run++;
      failures++;
      $display("FAIL %s: check never reached, required output not seen", name_q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
